// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch requester
//   (IF) and the load/store requester (D). D wins by fixed priority unless
//   IF has been passed over STARVE_MAX times in a row while waiting, in
//   which case IF is forced through. Each access is one mem_en strobe,
//   MEM_LAT cycles of wait, then a one-cycle ack to the winner.
//
// Ports
//   clk, rst                    clock (rising edge), sync active-low reset
//   if_req/if_addr              IF read request, held until if_ack
//   if_rdata/if_ack             IF read data + one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata   D read/write request, held until d_ack
//   d_rdata/d_ack               D read data + one-cycle completion pulse
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         memory port; mem_rdata valid MEM_LAT
//                               cycles after the mem_en cycle
//   busy                        high whenever a transaction is in progress
//   owner                       current or last grant (0 = IF, 1 = D)
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            grant_d_req;

  logic            mem_en_d, mem_we_d, owner_d, busy_d, if_ack_d, d_ack_d;
  logic [AW-1:0]   mem_addr_d;
  logic [DW-1:0]   mem_wdata_d, if_rdata_d, d_rdata_d;

  // Saturating increment of the starvation counter.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v >= SW'(STARVE_MAX)) ? v : v + SW'(1);
  endfunction

  // D wins a contested slot unless IF has already been skipped enough times.
  assign grant_d_req = d_req && !(if_req && (starve_q >= SW'(STARVE_MAX)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    owner_d     = owner;
    busy_d      = busy;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
          owner_d  = grant_d_req;
          if (grant_d_req) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // Only a D grant that actually skipped a waiting IF counts.
            if (if_req) starve_d = sat_inc(starve_q);
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            starve_d   = '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CW'(MEM_LAT);
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          // mem_we still holds the latched direction of this transaction.
          if (!mem_we) begin
            if (owner) d_rdata_d  = mem_rdata;
            else       if_rdata_d = mem_rdata;
          end
          if (owner) d_ack_d  = 1'b1;
          else       if_ack_d = 1'b1;
        end
      end
      DONE: begin
        // Requests are ignored here so the requester can drop req after ack.
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      starve_q  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      owner     <= owner_d;
      busy      <= busy_d;
      if_ack    <= if_ack_d;
      d_ack     <= d_ack_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// each grant, memory strobe and ack; a monitor compares the DUT every cycle.
module tb_mem_port_arbiter;
  localparam int L  = 3;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, busy, owner;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          drop;
  } cmd_t;

  txn_t exp_mem[$];
  txn_t exp_ack[$];
  cmd_t if_q[$];
  cmd_t d_q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          next_idle = 0;
  int          if_gr_cnt = 0;
  int          d_gr_cnt  = 0;
  logic [31:0] m_if_rd = '0;
  logic [31:0] m_d_rd  = '0;
  logic        m_owner = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'h2002_0001 : (32'h5A00_0000 ^ (i * 32'h0101_0103));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " if_rdata"},  if_rdata,  32'h0);
    chk({tag, " d_rdata"},   d_rdata,   32'h0);
    chk({tag, " mem_addr"},  mem_addr,  32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, " ctrl"}, 32'({if_ack, d_ack, mem_en, mem_we, busy, owner}), 32'h0);
  endtask

  // Memory environment: fixed-latency read pipe, garbage outside valid slots.
  logic [31:0] mem [32];
  logic [31:0] dl  [L];
  assign mem_rdata = dl[L-1];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = init_word(i);
    for (int i = 0; i < L; i++) dl[i] = '0;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) mem[mem_addr[6:2]] <= mem_wdata;
      dl[0] <= (mem_en && !mem_we) ? mem[mem_addr[6:2]] : $urandom;
      for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
    end
  end

  // Reference model: one transaction at a time, grant rule applied in IDLE.
  initial begin
    logic [31:0] ref_mem [32];
    int          starve;
    int          pend_cap;
    bit          pend_v;
    txn_t        pend, t;
    logic        who;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    starve = 0; pend_v = 0; pend_cap = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        exp_mem.delete(); exp_ack.delete();
        starve = 0; pend_v = 0;
        m_if_rd = '0; m_d_rd = '0; m_owner = 1'b0;
        next_idle = cyc + 1;
      end else begin
        if (pend_v && cyc == pend_cap) begin
          if (!pend.we) begin
            if (pend.who) m_d_rd = pend.rdata;
            else          m_if_rd = pend.rdata;
          end
          pend_v = 0;
        end
        if (cyc >= next_idle && (if_req || d_req)) begin
          who = d_req && !(if_req && starve >= SM);
          t.rdata = '0;
          if (who) begin
            if (if_req && starve < SM) starve++;
            t.we = d_we; t.addr = d_addr; t.wdata = d_wdata;
            d_gr_cnt++;
          end else begin
            starve = 0;
            t.we = 1'b0; t.addr = if_addr; t.wdata = '0;
            if_gr_cnt++;
          end
          if (t.we) ref_mem[t.addr[6:2]] = t.wdata;
          else      t.rdata = ref_mem[t.addr[6:2]];
          t.who = who;
          t.cyc = cyc + 1;     exp_mem.push_back(t);
          t.cyc = cyc + 2 + L; exp_ack.push_back(t);
          pend = t; pend_v = 1; pend_cap = cyc + 1 + L;
          next_idle = cyc + 3 + L;
          m_owner = who;
        end
      end
      cyc++;
    end
  end

  // Monitor: compares every cycle, popping expectations when they fall due.
  initial begin
    txn_t t;
    bit   e_en, e_ia, e_da, e_busy;
    forever begin
      @(negedge clk);
      e_en = exp_mem.size() > 0 && exp_mem[0].cyc == cyc;
      chk("mem_en", 32'(mem_en), 32'(e_en));
      if (e_en) begin
        t = exp_mem.pop_front();
        chk("mem_we", 32'(mem_we), 32'(t.we));
        chk("mem_addr", mem_addr, t.addr);
        if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
      end
      e_ia = exp_ack.size() > 0 && exp_ack[0].cyc == cyc && !exp_ack[0].who;
      e_da = exp_ack.size() > 0 && exp_ack[0].cyc == cyc &&  exp_ack[0].who;
      chk("if_ack", 32'(if_ack), 32'(e_ia));
      chk("d_ack",  32'(d_ack),  32'(e_da));
      if (e_ia || e_da) t = exp_ack.pop_front();
      e_busy = (cyc >= next_idle - (2 + L)) && (cyc <= next_idle - 1);
      chk("busy",     32'(busy),  32'(e_busy));
      chk("owner",    32'(owner), 32'(m_owner));
      chk("if_rdata", if_rdata, m_if_rd);
      chk("d_rdata",  d_rdata,  m_d_rd);
    end
  end

  // IF requester driver.
  initial begin
    bit busy_r = 0; int waitc = 0; int seen = 0;
    if_req = 1'b0; if_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy_r) if_q.delete(0);
        busy_r = 0; if_req = 1'b0;
      end else begin
        if (busy_r) begin
          if (if_ack) begin
            if_q.delete(0); busy_r = 0;
          end else if (++waitc > 100) begin
            n_tests++; n_fail++;
            $display("FAIL if_ack timeout: got no ack, required ack within 100 cycles");
            if_q.delete(0); busy_r = 0;
          end else if (if_q[0].drop && if_gr_cnt != seen) begin
            if_req = 1'b0; if_addr = $urandom;
          end
        end
        if (!busy_r) begin
          if (if_q.size() > 0) begin
            if_req = 1'b1; if_addr = if_q[0].addr;
            busy_r = 1; waitc = 0; seen = if_gr_cnt;
          end else if_req = 1'b0;
        end
      end
    end
  end

  // D requester driver.
  initial begin
    bit busy_r = 0; int waitc = 0; int seen = 0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy_r) d_q.delete(0);
        busy_r = 0; d_req = 1'b0;
      end else begin
        if (busy_r) begin
          if (d_ack) begin
            d_q.delete(0); busy_r = 0;
          end else if (++waitc > 100) begin
            n_tests++; n_fail++;
            $display("FAIL d_ack timeout: got no ack, required ack within 100 cycles");
            d_q.delete(0); busy_r = 0;
          end else if (d_q[0].drop && d_gr_cnt != seen) begin
            d_req = 1'b0; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
          end
        end
        if (!busy_r) begin
          if (d_q.size() > 0) begin
            d_req = 1'b1; d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
            busy_r = 1; waitc = 0; seen = d_gr_cnt;
          end else d_req = 1'b0;
        end
      end
    end
  end

  task automatic drain();
    int k = 0;
    while ((if_q.size() != 0 || d_q.size() != 0 || exp_ack.size() != 0) && k < 3000) begin
      @(negedge clk); k++;
    end
    n_tests++;
    if (k >= 3000) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, required 0", exp_ack.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int g, k;
    cmd_t c;
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, k;
    cmd_t c;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    // Single IF read of address 4.
    @(posedge clk);
    if_q.push_back('{1'b0, 32'h0000_0004, 32'h0, 1'b0});
    drain();

    // D write then read of the same word, back to back.
    @(posedge clk);
    d_q.push_back('{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0});
    d_q.push_back('{1'b0, 32'h0000_0040, 32'h0, 1'b0});
    drain();

    // Simultaneous requests from IDLE.
    @(posedge clk);
    if_q.push_back('{1'b0, 32'h0000_0008, 32'h0, 1'b0});
    d_q.push_back('{1'b0, 32'h0000_000C, 32'h0, 1'b0});
    drain();

    // Starvation: IF waits behind a stream of D requests.
    @(posedge clk);
    for (int i = 0; i < 6; i++)
      d_q.push_back('{1'(i & 1), 32'(i * 4 + 32'h80), 32'(32'hA500_0000 + i), 1'b0});
    if_q.push_back('{1'b0, 32'h0000_0010, 32'h0, 1'b0});
    drain();

    // Early request drop after grant.
    @(posedge clk);
    d_q.push_back('{1'b0, 32'h0000_0040, 32'h0, 1'b1});
    drain();

    // Reset while a D read is in WAIT.
    @(posedge clk);
    d_q.push_back('{1'b0, 32'h0000_0010, 32'h0, 1'b0});
    g = d_gr_cnt; k = 0;
    while (d_gr_cnt == g && k < 50) begin @(negedge clk); k++; end
    chk("reset-test grant", 32'(d_gr_cnt != g), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("mid-wait reset");
    @(negedge clk);
    rst = 1'b1;
    drain();

    // Randomized traffic.
    repeat (400) begin
      @(posedge clk);
      if (if_q.size() < 2 && $urandom_range(0, 3) == 0) begin
        c.we = 1'b0; c.addr = $urandom; c.wdata = '0; c.drop = ($urandom_range(0, 4) == 0);
        if_q.push_back(c);
      end
      if (d_q.size() < 2 && $urandom_range(0, 2) == 0) begin
        c.we = 1'($urandom); c.addr = $urandom; c.wdata = $urandom; c.drop = ($urandom_range(0, 4) == 0);
        d_q.push_back(c);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
